// File: rtl/cern_be_vme_master.sv
// Single-outstanding initiator for the cern-be-vme register bus: turns host
// requests into one-cycle VMERdMem/VMEWrMem strobes and returns data/status.
module cern_be_vme_master #(
   parameter int ADDR_WIDTH     = 20,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-3:0] adr_i,
   input  logic [31:0]           dat_i,
   output logic                  busy_o,
   output logic                  ack_o,
   output logic                  err_o,
   output logic [31:0]           rdat_o,
   output logic [7:0]            tmo_cnt_o,
   output logic [ADDR_WIDTH-3:0] VMEAddr,
   output logic [31:0]           VMEWrData,
   output logic                  VMERdMem,
   output logic                  VMEWrMem,
   input  logic [31:0]           VMERdData,
   input  logic                  VMERdDone,
   input  logic                  VMEWrDone
);

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} stateT;

   // Timer counts completed WAIT cycles; the last allowed value ends the wait.
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   stateT       state;
   logic        isWrite;
   logic [15:0] timer;
   logic        doneHit;

   assign doneHit = isWrite ? VMEWrDone : VMERdDone;

   // Single registered FSM; Done is already honoured in the STROBE cycle, and
   // a Done arriving with the timeout takes priority over the error.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         isWrite   <= 1'b0;
         timer     <= '0;
         busy_o    <= 1'b0;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         rdat_o    <= '0;
         tmo_cnt_o <= '0;
         VMEAddr   <= '0;
         VMEWrData <= '0;
         VMERdMem  <= 1'b0;
         VMEWrMem  <= 1'b0;
      end else begin
         ack_o    <= 1'b0;
         err_o    <= 1'b0;
         VMERdMem <= 1'b0;
         VMEWrMem <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  isWrite   <= we_i;
                  VMEAddr   <= adr_i;
                  VMEWrData <= dat_i;
                  busy_o    <= 1'b1;
                  VMERdMem  <= ~we_i;
                  VMEWrMem  <= we_i;
                  state     <= STROBE;
               end
            end
            STROBE, WAIT: begin
               timer <= (state == STROBE) ? 16'd0 : timer + 16'd1;
               if (doneHit) begin
                  if (!isWrite) rdat_o <= VMERdData;
                  ack_o  <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= RESP;
               end else if (state == WAIT && timer == TIMER_LAST) begin
                  if (!isWrite) rdat_o <= 32'hFFFF_FFFF;
                  if (tmo_cnt_o != 8'hFF) tmo_cnt_o <= tmo_cnt_o + 8'd1;
                  ack_o  <= 1'b1;
                  err_o  <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cern_be_vme_master.sv
// Directed self-checking bench for cern_be_vme_master (TIMEOUT_CYCLES = 8).
module tb_cern_be_vme_master;

   localparam int AW  = 20;
   localparam int TMO = 8;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          req_i, we_i;
   logic [AW-3:0] adr_i;
   logic [31:0]   dat_i;
   logic          busy_o, ack_o, err_o;
   logic [31:0]   rdat_o;
   logic [7:0]    tmo_cnt_o;
   logic [AW-3:0] VMEAddr;
   logic [31:0]   VMEWrData;
   logic          VMERdMem, VMEWrMem;
   logic [31:0]   VMERdData;
   logic          VMERdDone, VMEWrDone;

   int testCount = 0;
   int failCount = 0;
   int rdStrobes = 0;
   int wrStrobes = 0;

   cern_be_vme_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .Clk(Clk), .Rst(Rst), .req_i(req_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
      .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .rdat_o(rdat_o), .tmo_cnt_o(tmo_cnt_o),
      .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
      .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
   );

   always #5 Clk = ~Clk;

   // Strobe pulses counted once per clock edge they are high for.
   always @(posedge Clk) begin
      if (VMERdMem) rdStrobes++;
      if (VMEWrMem) wrStrobes++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [AW-3:0] adr, input logic [31:0] dat);
      req_i = req;
      we_i  = we;
      adr_i = adr;
      dat_i = dat;
   endtask

   task automatic stepCycle();
      @(negedge Clk);
   endtask

   // Issues one transaction from an IDLE negedge; doneAt/wrongAt are cycle
   // offsets from the strobe cycle for the matching/non-matching Done (-1 = none).
   task automatic runTxn(input string tag, input logic we, input logic [AW-3:0] adr, input logic [31:0] dat,
                         input int doneAt, input int wrongAt, input logic [31:0] rdData, input int expAckAt,
                         input logic expErr, input logic [31:0] expRdat, input logic [7:0] expTmo);
      int strobesBefore;
      strobesBefore = rdStrobes + wrStrobes;
      applyStimulus(1'b1, we, adr, dat);
      VMERdData = rdData;
      for (int k = 0; k <= expAckAt; k++) begin
         stepCycle();
         if (k == 0) begin
            req_i = 1'b0;
            checkOutput({tag, ":rdStrobe"}, {31'd0, VMERdMem}, {31'd0, ~we});
            checkOutput({tag, ":wrStrobe"}, {31'd0, VMEWrMem}, {31'd0, we});
            checkOutput({tag, ":addr"}, {14'd0, VMEAddr}, {14'd0, adr});
            checkOutput({tag, ":busy"}, {31'd0, busy_o}, 32'd1);
            if (we) checkOutput({tag, ":wdata"}, VMEWrData, dat);
         end else if (k == 1) begin
            checkOutput({tag, ":strobeDrop"}, {30'd0, VMERdMem, VMEWrMem}, 32'd0);
         end
         checkOutput({tag, ":ack"}, {31'd0, ack_o}, {31'd0, (k == expAckAt)});
         if (k == expAckAt) begin
            checkOutput({tag, ":err"}, {31'd0, err_o}, {31'd0, expErr});
            checkOutput({tag, ":busyDrop"}, {31'd0, busy_o}, 32'd0);
            checkOutput({tag, ":rdat"}, rdat_o, expRdat);
            checkOutput({tag, ":tmoCnt"}, {24'd0, tmo_cnt_o}, {24'd0, expTmo});
            checkOutput({tag, ":addrHeld"}, {14'd0, VMEAddr}, {14'd0, adr});
         end
         VMEWrDone = (k == doneAt && we) || (k == wrongAt && !we);
         VMERdDone = (k == doneAt && !we) || (k == wrongAt && we);
      end
      VMEWrDone = 1'b0;
      VMERdDone = 1'b0;
      stepCycle();
      checkOutput({tag, ":ackPulse"}, {31'd0, ack_o}, 32'd0);
      checkOutput({tag, ":idleBusy"}, {31'd0, busy_o}, 32'd0);
      checkOutput({tag, ":strobeCount"}, rdStrobes + wrStrobes - strobesBefore, 32'd1);
   endtask

   initial begin
      int base;
      Rst       = 1'b1;
      VMERdData = '0;
      VMERdDone = 1'b0;
      VMEWrDone = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0);
      #12;
      checkOutput("rst:busy", {31'd0, busy_o}, 32'd0);
      checkOutput("rst:ackErr", {30'd0, ack_o, err_o}, 32'd0);
      checkOutput("rst:strobes", {30'd0, VMERdMem, VMEWrMem}, 32'd0);
      checkOutput("rst:addr", {14'd0, VMEAddr}, 32'd0);
      checkOutput("rst:wdata", VMEWrData, 32'd0);
      checkOutput("rst:rdat", rdat_o, 32'd0);
      checkOutput("rst:tmo", {24'd0, tmo_cnt_o}, 32'd0);
      @(negedge Clk);
      Rst = 1'b0;

      runTxn("wr4",    1'b1, 18'h00004, 32'h1234_5678, 2, -1, 32'h0,         3, 1'b0, 32'h0,         8'd0);
      runTxn("rdMin",  1'b0, 18'h00001, 32'h0,         0, -1, 32'hA5A5_0001, 1, 1'b0, 32'hA5A5_0001, 8'd0);
      runTxn("rdCafe", 1'b0, 18'h00001, 32'h0,         2,  1, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 8'd0);
      runTxn("wrHold", 1'b1, 18'h2AAAA, 32'hDEAD_BEEF, 1,  0, 32'h1111_1111, 2, 1'b0, 32'hCAFE_F00D, 8'd0);
      runTxn("rdTmo",  1'b0, 18'h00003, 32'h0,        -1, -1, 32'h2222_2222, 9, 1'b1, 32'hFFFF_FFFF, 8'd1);
      runTxn("rdEdge", 1'b0, 18'h00005, 32'h0,         8, -1, 32'h0BAD_BEEF, 9, 1'b0, 32'h0BAD_BEEF, 8'd1);
      runTxn("wrTmo",  1'b1, 18'h00006, 32'h55AA_55AA, -1, -1, 32'h0,        9, 1'b1, 32'h0BAD_BEEF, 8'd2);

      for (int n = 0; n < 298; n++) begin
         applyStimulus(1'b1, 1'b0, 18'h00007, 32'h0);
         stepCycle();
         req_i = 1'b0;
         repeat (10) stepCycle();
      end
      checkOutput("sat:tmo", {24'd0, tmo_cnt_o}, 32'd255);
      checkOutput("sat:rdat", rdat_o, 32'hFFFF_FFFF);

      base = wrStrobes;
      applyStimulus(1'b1, 1'b1, 18'h00010, 32'hAAAA_0010);
      stepCycle();
      checkOutput("b2b:firstStrobe", {31'd0, VMEWrMem}, 32'd1);
      checkOutput("b2b:firstAddr", {14'd0, VMEAddr}, 32'h10);
      adr_i     = 18'h00020;
      dat_i     = 32'hBBBB_0020;
      VMEWrDone = 1'b1;
      stepCycle();
      VMEWrDone = 1'b0;
      checkOutput("b2b:firstAck", {31'd0, ack_o}, 32'd1);
      checkOutput("b2b:addrHeld", {14'd0, VMEAddr}, 32'h10);
      checkOutput("b2b:noStrobeResp", {31'd0, VMEWrMem}, 32'd0);
      stepCycle();
      checkOutput("b2b:idleAck", {31'd0, ack_o}, 32'd0);
      checkOutput("b2b:idleBusy", {31'd0, busy_o}, 32'd0);
      checkOutput("b2b:noStrobeIdle", {31'd0, VMEWrMem}, 32'd0);
      stepCycle();
      checkOutput("b2b:secondStrobe", {31'd0, VMEWrMem}, 32'd1);
      checkOutput("b2b:secondAddr", {14'd0, VMEAddr}, 32'h20);
      checkOutput("b2b:secondData", VMEWrData, 32'hBBBB_0020);
      checkOutput("b2b:secondBusy", {31'd0, busy_o}, 32'd1);
      req_i     = 1'b0;
      VMEWrDone = 1'b1;
      stepCycle();
      VMEWrDone = 1'b0;
      checkOutput("b2b:secondAck", {31'd0, ack_o}, 32'd1);
      checkOutput("b2b:secondErr", {31'd0, err_o}, 32'd0);
      stepCycle();
      checkOutput("b2b:strobeTotal", wrStrobes - base, 32'd2);

      applyStimulus(1'b1, 1'b0, 18'h00009, 32'h0);
      stepCycle();
      req_i = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("rstWait:busyBefore", {31'd0, busy_o}, 32'd1);
      #2 Rst = 1'b1;
      #1;
      checkOutput("rstWait:busy", {31'd0, busy_o}, 32'd0);
      checkOutput("rstWait:ack", {31'd0, ack_o}, 32'd0);
      checkOutput("rstWait:strobes", {30'd0, VMERdMem, VMEWrMem}, 32'd0);
      checkOutput("rstWait:tmo", {24'd0, tmo_cnt_o}, 32'd0);
      checkOutput("rstWait:rdat", rdat_o, 32'd0);
      @(negedge Clk);
      Rst       = 1'b0;
      VMERdDone = 1'b1;
      stepCycle();
      VMERdDone = 1'b0;
      checkOutput("rstWait:lateDoneAck", {31'd0, ack_o}, 32'd0);
      stepCycle();
      checkOutput("rstWait:lateDoneAck2", {31'd0, ack_o}, 32'd0);
      checkOutput("rstWait:idleBusy", {31'd0, busy_o}, 32'd0);

      applyStimulus(1'b1, 1'b0, 18'h0000A, 32'h0);
      stepCycle();
      req_i = 1'b0;
      checkOutput("rstStrobe:before", {31'd0, VMERdMem}, 32'd1);
      #2 Rst = 1'b1;
      #1;
      checkOutput("rstStrobe:drop", {31'd0, VMERdMem}, 32'd0);
      @(negedge Clk);
      Rst = 1'b0;
      stepCycle();

      runTxn("postRst", 1'b0, 18'h3FFFF, 32'h0, 1, -1, 32'h7654_3210, 2, 1'b0, 32'h7654_3210, 8'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
